// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite slave register bank.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  localparam int REG_IDX_LSB = 2;
  localparam int BYTE_W      = 8;

endpackage

// File: rtl/axil_reg_bank.sv
// Software register storage: one byte-strobed write port, one combinational read port.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(NUM_REGS),
  localparam int STRB_W    = DATA_WIDTH / BYTE_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wrEn_i,
  input  logic [IDX_W-1:0]      wrIdx_i,
  input  logic [DATA_WIDTH-1:0] wrData_i,
  input  logic [STRB_W-1:0]     wrStrb_i,
  input  logic [IDX_W-1:0]      rdIdx_i,
  output logic [DATA_WIDTH-1:0] rdData_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (wrEn_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wrStrb_i[b]) begin
          regs_d[wrIdx_i][b*BYTE_W +: BYTE_W] = wrData_i[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read sees the pre-write contents when both hit the same register on one edge.
  assign rdData_o = regs_q[rdIdx_i];

endmodule

// File: rtl/axil_slave_regs.sv
// AXI4-Lite slave register bank with independent write and read FSMs.
// Define AXIL_ADDR_CHECK_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axil_slave_regs
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_t             wrState_q, wrState_d;
  logic [ADDR_WIDTH-1:0] awAddr_q, awAddr_d;
  logic [DATA_WIDTH-1:0] wData_q, wData_d;
  logic [STRB_W-1:0]     wStrb_q, wStrb_d;
  resp_t                 bResp_q, bResp_d;

  rd_state_t             rdState_q, rdState_d;
  logic [DATA_WIDTH-1:0] rData_q, rData_d;
  resp_t                 rResp_q, rResp_d;

  logic                  awHs, wHs, arHs, commit, bankWe;
  logic                  wrInRange, rdInRange;
  logic [ADDR_WIDTH-1:0] cmtAddr;
  logic [DATA_WIDTH-1:0] cmtData, bankRdData;
  logic [STRB_W-1:0]     cmtStrb;
  logic [IDX_W-1:0]      wrIdx, rdIdx;
  logic                  unusedAddrBits;

  assign AWREADY = (wrState_q == W_IDLE) || (wrState_q == W_HAVE_DATA);
  assign WREADY  = (wrState_q == W_IDLE) || (wrState_q == W_HAVE_ADDR);
  assign BVALID  = (wrState_q == W_RESP);
  assign BRESP   = bResp_q;
  assign ARREADY = (rdState_q == R_IDLE);
  assign RVALID  = (rdState_q == R_DATA);
  assign RDATA   = rData_q;
  assign RRESP   = rResp_q;

  assign awHs = AWVALID && AWREADY;
  assign wHs  = WVALID && WREADY;
  assign arHs = ARVALID && ARREADY;

  // Whichever channel arrived first was latched; the other comes straight off the bus.
  assign cmtAddr = (wrState_q == W_HAVE_ADDR) ? awAddr_q : AWADDR;
  assign cmtData = (wrState_q == W_HAVE_DATA) ? wData_q  : WDATA;
  assign cmtStrb = (wrState_q == W_HAVE_DATA) ? wStrb_q  : WSTRB;

  assign wrIdx = cmtAddr[REG_IDX_LSB +: IDX_W];
  assign rdIdx = ARADDR[REG_IDX_LSB +: IDX_W];

`ifdef AXIL_ADDR_CHECK_EN
  assign wrInRange = (cmtAddr >> (REG_IDX_LSB + IDX_W)) == '0;
  assign rdInRange = (ARADDR  >> (REG_IDX_LSB + IDX_W)) == '0;
`else
  assign wrInRange = 1'b1;
  assign rdInRange = 1'b1;
`endif

  // Byte-offset bits (and the upper bits when wrapping) never select anything.
  assign unusedAddrBits = ^{cmtAddr, ARADDR};

  assign bankWe = commit && wrInRange;

  always_comb begin
    wrState_d = wrState_q;
    awAddr_d  = awAddr_q;
    wData_d   = wData_q;
    wStrb_d   = wStrb_q;
    bResp_d   = bResp_q;
    commit    = 1'b0;
    case (wrState_q)
      W_IDLE: begin
        if (awHs && wHs) begin
          commit = 1'b1;
        end else if (awHs) begin
          awAddr_d  = AWADDR;
          wrState_d = W_HAVE_ADDR;
        end else if (wHs) begin
          wData_d   = WDATA;
          wStrb_d   = WSTRB;
          wrState_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: commit = wHs;
      W_HAVE_DATA: commit = awHs;
      W_RESP: begin
        if (BREADY) wrState_d = W_IDLE;
      end
      default: wrState_d = W_IDLE;
    endcase
    if (commit) begin
      wrState_d = W_RESP;
      bResp_d   = wrInRange ? OKAY : SLVERR;
    end
  end

  always_comb begin
    rdState_d = rdState_q;
    rData_d   = rData_q;
    rResp_d   = rResp_q;
    case (rdState_q)
      R_IDLE: begin
        if (arHs) begin
          rdState_d = R_DATA;
          rData_d   = rdInRange ? bankRdData : '0;
          rResp_d   = rdInRange ? OKAY : SLVERR;
        end
      end
      R_DATA: begin
        if (RREADY) rdState_d = R_IDLE;
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wrState_q <= W_IDLE;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      bResp_q   <= OKAY;
      rdState_q <= R_IDLE;
      rData_q   <= '0;
      rResp_q   <= OKAY;
    end else begin
      wrState_q <= wrState_d;
      awAddr_q  <= awAddr_d;
      wData_q   <= wData_d;
      wStrb_q   <= wStrb_d;
      bResp_q   <= bResp_d;
      rdState_q <= rdState_d;
      rData_q   <= rData_d;
      rResp_q   <= rResp_d;
    end
  end

  axil_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_regBank (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .wrEn_i  (bankWe),
    .wrIdx_i (wrIdx),
    .wrData_i(cmtData),
    .wrStrb_i(cmtStrb),
    .rdIdx_i (rdIdx),
    .rdData_o(bankRdData)
  );

endmodule

// File: tb/tb_axil_slave_regs.sv
// Scoreboard bench for axil_slave_regs: drivers push expected responses, a monitor pops and compares.
module tb_axil_slave_regs;

  localparam int NUM_REGS = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int checkCount = 0;
  int errCount   = 0;

  logic [31:0] modelRegs [NUM_REGS];
  logic [1:0]  expBQ [$];
  logic [33:0] expRQ [$];

  axil_slave_regs #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (NUM_REGS)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .AWADDR (AWADDR),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA  (WDATA),
    .WSTRB  (WSTRB),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .BRESP  (BRESP),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .ARADDR (ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RVALID (RVALID),
    .RREADY (RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: byte-addressed word registers, wrap or reject depending on the build.
  function automatic bit addrInRange(input logic [31:0] a);
`ifdef AXIL_ADDR_CHECK_EN
    return a < NUM_REGS * 4;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int regIndex(input logic [31:0] a);
    return int'((a / 4) % NUM_REGS);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every completed B or R handshake is matched against the oldest expectation.
  always @(negedge ACLK) begin
    logic [33:0] e;
    if (!ARESET) begin
      if (BVALID && BREADY) begin
        if (expBQ.size() == 0) begin
          checkOutput("unexpectedB", 32'd1, 32'd0);
        end else begin
          e = 34'(expBQ.pop_front());
          checkOutput("bresp", 32'(BRESP), 32'(e[1:0]));
        end
      end
      if (RVALID && RREADY) begin
        if (expRQ.size() == 0) begin
          checkOutput("unexpectedR", 32'd1, 32'd0);
        end else begin
          e = expRQ.pop_front();
          checkOutput("rdata", RDATA, e[31:0]);
          checkOutput("rresp", 32'(RRESP), 32'(e[33:32]));
        end
      end
    end
  end

  task automatic waitHandshake(input int which);
    int n;
    n = 0;
    forever begin
      @(negedge ACLK);
      if ((which == 0 && AWREADY) || (which == 1 && WREADY) || (which == 2 && ARREADY)) break;
      n++;
      if (n >= 50) begin
        checkOutput("handshakeTimeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic waitResp(input bit isRead);
    int n;
    n = 0;
    while (!(isRead ? (RVALID && RREADY) : (BVALID && BREADY)) && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!(isRead ? (RVALID && RREADY) : (BVALID && BREADY)))
      checkOutput(isRead ? "rTimeout" : "bTimeout", 32'd0, 32'd1);
    @(posedge ACLK);
    #1;
  endtask

  task automatic driveWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awDelay, input int wDelay, input int bHold);
    logic [1:0] expResp;
    int idx;
    expResp = addrInRange(addr) ? 2'b00 : 2'b10;
    idx = regIndex(addr);
    expBQ.push_back(expResp);
    BREADY = (bHold == 0);
    fork
      begin
        repeat (awDelay) begin @(posedge ACLK); #1; end
        AWADDR = addr;
        AWVALID = 1'b1;
        waitHandshake(0);
        AWVALID = 1'b0;
      end
      begin
        repeat (wDelay) begin @(posedge ACLK); #1; end
        WDATA = data;
        WSTRB = strb;
        WVALID = 1'b1;
        waitHandshake(1);
        WVALID = 1'b0;
      end
    join
    if (addrInRange(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) modelRegs[idx][8*b +: 8] = data[8*b +: 8];
    @(negedge ACLK);
    checkOutput("bvalidLatency", 32'(BVALID), 32'd1);
    for (int i = 0; i < bHold; i++) begin
      if (i > 0) @(negedge ACLK);
      AWADDR = addr ^ 32'h4;
      AWVALID = 1'b1;
      checkOutput("bvalidHeld", 32'(BVALID), 32'd1);
      checkOutput("brespHeld", 32'(BRESP), 32'(expResp));
      checkOutput("awreadyHeld", 32'(AWREADY), 32'd0);
    end
    if (bHold > 0) begin
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
      BREADY = 1'b1;
    end
    waitResp(1'b0);
  endtask

  task automatic driveRead(input logic [31:0] addr, input int rHold);
    logic [31:0] expData;
    logic [1:0]  expResp;
    expData = addrInRange(addr) ? modelRegs[regIndex(addr)] : 32'h0;
    expResp = addrInRange(addr) ? 2'b00 : 2'b10;
    expRQ.push_back({expResp, expData});
    RREADY = (rHold == 0);
    ARADDR = addr;
    ARVALID = 1'b1;
    waitHandshake(2);
    ARVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("rvalidLatency", 32'(RVALID), 32'd1);
    for (int i = 0; i < rHold; i++) begin
      if (i > 0) @(negedge ACLK);
      ARADDR = addr ^ 32'h4;
      ARVALID = 1'b1;
      checkOutput("rvalidHeld", 32'(RVALID), 32'd1);
      checkOutput("rdataHeld", RDATA, expData);
      checkOutput("arreadyHeld", 32'(ARREADY), 32'd0);
    end
    if (rHold > 0) begin
      @(posedge ACLK);
      #1;
      ARVALID = 1'b0;
      RREADY = 1'b1;
    end
    waitResp(1'b1);
  endtask

  task automatic checkIdle(input string tag);
    @(negedge ACLK);
    checkOutput({tag, "Awready"}, 32'(AWREADY), 32'd1);
    checkOutput({tag, "Wready"},  32'(WREADY),  32'd1);
    checkOutput({tag, "Arready"}, 32'(ARREADY), 32'd1);
    checkOutput({tag, "Bvalid"},  32'(BVALID),  32'd0);
    checkOutput({tag, "Rvalid"},  32'(RVALID),  32'd0);
    checkOutput({tag, "Bresp"},   32'(BRESP),   32'd0);
    checkOutput({tag, "Rresp"},   32'(RRESP),   32'd0);
    checkOutput({tag, "Rdata"},   RDATA,        32'd0);
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input int count);
    logic [31:0] a, d;
    logic [3:0]  s;
    int op;
    for (int i = 0; i < count; i++) begin
      op = $urandom_range(0, 4);
      a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      case (op)
        0, 1: driveWrite(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        2, 3: driveRead(a, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        default: begin
          fork
            driveWrite(a, d, s, 0, 0, 0);
            driveRead(a, 0);
          join
        end
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = 32'h0;
    ARESET = 1'b1;
    AWADDR = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    ARADDR = '0; ARVALID = 1'b0;
    BREADY = 1'b1; RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    checkIdle("reset");

    $display("[TB] basic write/read");
    driveWrite(32'h0, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    driveRead(32'h0, 0);

    $display("[TB] split AW then W");
    fork
      driveWrite(32'h8, 32'hCAFEF00D, 4'hF, 0, 3, 0);
      begin
        @(negedge ACLK);
        for (int i = 0; i < 3; i++) begin
          @(negedge ACLK);
          checkOutput("awreadyWaitW", 32'(AWREADY), 32'd0);
          checkOutput("bvalidEarlyAw", 32'(BVALID), 32'd0);
        end
        @(negedge ACLK);
        checkOutput("bvalidAfterW", 32'(BVALID), 32'd1);
      end
    join
    $display("[TB] split W then AW");
    fork
      driveWrite(32'h8, 32'hCAFEF00D, 4'hF, 3, 0, 0);
      begin
        @(negedge ACLK);
        for (int i = 0; i < 3; i++) begin
          @(negedge ACLK);
          checkOutput("wreadyWaitAw", 32'(WREADY), 32'd0);
          checkOutput("bvalidEarlyW", 32'(BVALID), 32'd0);
        end
        @(negedge ACLK);
        checkOutput("bvalidAfterAw", 32'(BVALID), 32'd1);
      end
    join
    driveRead(32'h8, 0);

    $display("[TB] byte strobes");
    driveWrite(32'h4, 32'h12345678, 4'hF, 0, 0, 0);
    driveWrite(32'h4, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    driveRead(32'h4, 0);
    driveWrite(32'h4, 32'hFFFFFFFF, 4'b0000, 1, 0, 0);
    driveRead(32'h4, 0);

    $display("[TB] held responses");
    driveWrite(32'hC, 32'h0BADF00D, 4'hF, 0, 0, 5);
    driveRead(32'hC, 5);

    $display("[TB] address 0x10");
    driveWrite(32'h10, 32'h87654321, 4'hF, 0, 0, 0);
    driveRead(32'h0, 0);
    driveRead(32'h10, 0);

    $display("[TB] same-edge read and write");
    fork
      driveWrite(32'h8, 32'h55AA55AA, 4'hF, 0, 0, 0);
      driveRead(32'h8, 0);
    join
    driveRead(32'h8, 0);

    $display("[TB] random traffic");
    applyStimulus(60);

    $display("[TB] reset mid-transaction");
    BREADY = 1'b1;
    RREADY = 1'b0;
    AWADDR = 32'h4; AWVALID = 1'b1;
    ARADDR = 32'h8; ARVALID = 1'b1;
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0;
    ARVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("midAwready", 32'(AWREADY), 32'd0);
    checkOutput("midRvalid", 32'(RVALID), 32'd1);
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    RREADY = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = 32'h0;
    checkIdle("abort");
    repeat (3) @(posedge ACLK);
    #1;
    checkIdle("abortLater");
    for (int i = 0; i < NUM_REGS; i++) driveRead(32'(4 * i), 0);

    repeat (5) @(posedge ACLK);
    #1;
    checkOutput("pendingB", 32'(expBQ.size()), 32'd0);
    checkOutput("pendingR", 32'(expRQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
